i2s_audio_rx: RTL and testbench
===============================

# i2s_audio_rx

Deserializes stereo I2S audio from the codec ADC into parallel signed 32-bit left/right samples, with a one-cycle `audio_valid` strobe per completed frame. It sits at the front of the audio path. Its outputs drive `audio_in_L`, `audio_in_R` and `audio_valid` of downstream consumers such as the VU meter and effect stages. The codec is bit-clock master; this block is a slave that oversamples `bclk`, `lrck` and `adcdat` in the system clock domain.

## Interface
- `SAMPLE_WIDTH`, default 24: codec bits per channel slot. Legal range 16..32.
- `clock`  input  1: system clock, 50 MHz.
- `reset_n`  input  1: asynchronous, active-low reset.
- `bclk`  input  1: codec bit clock. Asynchronous to `clock`.
- `lrck`  input  1: codec word select. 0 = left slot, 1 = right slot. Asynchronous.
- `adcdat`  input  1: codec serial data, MSB first. Asynchronous.
- `audio_out_L`  output  32 (signed): left sample, left-aligned.
- `audio_out_R`  output  32 (signed): right sample, left-aligned.
- `audio_valid`  output  1: one-cycle strobe; both sample outputs are updated together in that cycle.
- `sample_error`  output  1: one-cycle strobe when a channel slot ends before `SAMPLE_WIDTH` bits have been captured.

## Operation
- **Synchronizers:** `bclk`, `lrck` and `adcdat` each pass through two flip-flop synchronizer stages. `bclk` has a third stage used for edge detection.
- **Bit-clock edge:** a `bclk` rising edge is detected when stage 2 = 1 and stage 3 = 0. All protocol actions below happen only on such an edge, using the stage-2 values of `lrck` and `adcdat`.
- **Slot boundary:** `prev_lrck` is updated on every `bclk` rise. A slot boundary is `lrck != prev_lrck`.
- **I2S framing:** the MSB arrives on the second `bclk` rise after an `lrck` transition (one-bit delay). Bits beyond `SAMPLE_WIDTH` in a slot are ignored.
- **FSM states:**
  - **IDLE:** wait for an `lrck` 1→0 boundary (left-slot start), then go to DELAY. Partial frames after reset are discarded.
  - **DELAY:** consume one `bclk` rise, then go to SHIFT. The bit counter is cleared and the channel is latched from `lrck`.
  - **SHIFT:** shift `adcdat` into the shift register, MSB first, once per `bclk` rise. After `SAMPLE_WIDTH` bits, complete the channel and go to WAIT.
  - **WAIT:** ignore bits until a slot boundary, then go to DELAY.
- **Channel completion:**
  - Left complete: load the left holding register and set `left_ok`.
  - Right complete with `left_ok` = 1: register outputs and pulse `audio_valid`, then clear `left_ok`.
  - Right complete with `left_ok` = 0: discard the sample; no strobe.
- **Short slot:** a boundary seen in SHIFT pulses `sample_error`. The partial word is discarded, `left_ok` is cleared, and the FSM goes to DELAY for the new slot.
- **Width rule:** output bits [31:32-`SAMPLE_WIDTH`] hold the captured word; the low bits are 0. The sign comes from the MSB; no sign extension is applied.
- **Hold behaviour:** `audio_out_L` and `audio_out_R` hold their values between strobes.

## Timing
- **Reset:** while `reset_n` = 0, all of the following are 0: outputs, synchronizer stages, shift register, `left_ok`, `prev_lrck`. The FSM is in IDLE.
- **Reset asserted mid-frame:** everything clears immediately. After release, the block resynchronizes at the next left-slot start.
- **Latency:** let E0 be the clock edge at which the `bclk` rise carrying the final right bit first enters sync stage 1.
  - The bit is captured at E2.
  - `audio_out_*` and `audio_valid` update at E3, and `audio_valid` is high for exactly the one cycle after E3.
  - `sample_error` uses the same E3 timing, relative to the `bclk` rise where the boundary is detected.
- **Clock ratio:** `bclk` high and low phases must each be at least 2 `clock` periods, i.e. `bclk` ≤ `clock`/4 (12.5 MHz). Slower `bclk` (e.g. 3.072 MHz = 64×48 kHz) is nominal.
- **Minimum slot length:** `SAMPLE_WIDTH`+1 `bclk` periods.
- **Throughput:** at most one `audio_valid` per frame. Strobes are never closer together than 2×(`SAMPLE_WIDTH`+1) `bclk` periods.
- **Simultaneous events:** a boundary that coincides with the final SHIFT bit counts as completion, not an error, because the bit count is already met.

## Test plan
- **Reset:** hold `reset_n` = 0 with `bclk` running → all outputs are 0. Release with `lrck` held constant → no `audio_valid` and no `sample_error`.
- **Nominal frame:** `SAMPLE_WIDTH`=24, 64 `bclk`/frame at 3.072 MHz, left = 24'h800001, right = 24'h7FFFFF → `audio_out_L` = 32'h80000100, `audio_out_R` = 32'h7FFFFF00. Exactly one `audio_valid` per frame, at E3 after the right LSB.
- **Mid-frame start:** release reset during a right slot → no strobe for that partial frame. The first `audio_valid` comes after the next complete left+right pair.
- **Short slot:** `lrck` toggles after 10 left bits → one `sample_error` pulse and no `audio_valid` for that frame. The following frame (left = 24'h123456, right = 24'hFEDCBA) outputs 32'h12345600 and 32'hFEDCBA00.
- **Minimum-length slots at maximum rate:** 25 `bclk` per slot at 12.5 MHz, with random data over 100 frames → 100 strobes, every sample matches the reference model, and `sample_error` is never asserted.
- **Reset mid-shift:** pulse `reset_n` low for 1 `clock` partway through a left slot → outputs clear immediately. Resynchronization happens at the next left-slot start, and the first strobe carries the correct full frame.

Source files
------------

// File: rtl/i2s_audio_rx_if.sv
// i2s_audio_rx_if
//   Bundles the codec-side serial lines and the parallel sample outputs of
//   the I2S receiver.
//   Signals:
//     bclk, lrck, adcdat         : codec bit clock, word select, serial data
//                                  (asynchronous to the system clock)
//     audio_out_L, audio_out_R   : signed left-aligned 32-bit samples
//     audio_valid                : one-cycle strobe, both samples updated
//     sample_error               : one-cycle strobe on a short channel slot
//   Modports:
//     slave  : the receiver (reads serial lines, drives sample outputs)
//     master : the codec/consumer side (drives serial lines, reads samples)
interface i2s_audio_rx_if;
  logic               bclk;
  logic               lrck;
  logic               adcdat;
  logic signed [31:0] audio_out_L;
  logic signed [31:0] audio_out_R;
  logic               audio_valid;
  logic               sample_error;

  modport slave (
    input  bclk, lrck, adcdat,
    output audio_out_L, audio_out_R, audio_valid, sample_error
  );

  modport master (
    output bclk, lrck, adcdat,
    input  audio_out_L, audio_out_R, audio_valid, sample_error
  );
endinterface

// File: rtl/i2s_audio_rx.sv
// i2s_audio_rx
//   Slave I2S receiver: oversamples bclk/lrck/adcdat in the system clock
//   domain and deserializes stereo frames into signed, left-aligned 32-bit
//   samples with a one-cycle audio_valid strobe per completed left+right pair.
//   Ports:
//     clock   : system clock (50 MHz)
//     reset_n : asynchronous active-low reset
//     bus     : i2s_audio_rx_if.slave (serial inputs, sample outputs, strobes)
//   Parameter:
//     SAMPLE_WIDTH : captured bits per channel slot, 16..32
module i2s_audio_rx #(
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic           clock,
  input  logic           reset_n,
  i2s_audio_rx_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_SHIFT,
    S_WAIT
  } state_t;

  state_t                  state_reg;
  logic [2:0]              bclk_sync_reg;
  logic [1:0]              lrck_sync_reg;
  logic [1:0]              adcdat_sync_reg;
  logic                    prev_lrck_reg;
  logic                    channel_reg;      // 0 = left slot, 1 = right slot
  logic [5:0]              bit_cnt_reg;
  logic [SAMPLE_WIDTH-1:0] shift_reg;
  logic [31:0]             left_hold_reg;
  logic                    left_ok_reg;
  logic                    done_left_reg;
  logic                    done_right_reg;
  logic                    short_reg;
  logic [31:0]             audio_l_reg;
  logic [31:0]             audio_r_reg;
  logic                    audio_valid_reg;
  logic                    sample_error_reg;

  logic bclk_rise;
  logic lrck_s;
  logic adcdat_s;
  logic boundary;

  assign bclk_rise = bclk_sync_reg[1] & ~bclk_sync_reg[2];
  assign lrck_s    = lrck_sync_reg[1];
  assign adcdat_s  = adcdat_sync_reg[1];
  assign boundary  = (lrck_s != prev_lrck_reg);

  // Place the captured word in the top bits; low bits stay zero.
  function automatic logic [31:0] align(input logic [SAMPLE_WIDTH-1:0] w);
    return 32'(w) << (32 - SAMPLE_WIDTH);
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= S_IDLE;
      bclk_sync_reg    <= '0;
      lrck_sync_reg    <= '0;
      adcdat_sync_reg  <= '0;
      prev_lrck_reg    <= 1'b0;
      channel_reg      <= 1'b0;
      bit_cnt_reg      <= '0;
      shift_reg        <= '0;
      left_hold_reg    <= '0;
      left_ok_reg      <= 1'b0;
      done_left_reg    <= 1'b0;
      done_right_reg   <= 1'b0;
      short_reg        <= 1'b0;
      audio_l_reg      <= '0;
      audio_r_reg      <= '0;
      audio_valid_reg  <= 1'b0;
      sample_error_reg <= 1'b0;
    end else begin
      bclk_sync_reg   <= {bclk_sync_reg[1:0], bus.bclk};
      lrck_sync_reg   <= {lrck_sync_reg[0], bus.lrck};
      adcdat_sync_reg <= {adcdat_sync_reg[0], bus.adcdat};

      done_left_reg    <= 1'b0;
      done_right_reg   <= 1'b0;
      short_reg        <= 1'b0;
      audio_valid_reg  <= 1'b0;
      sample_error_reg <= 1'b0;

      if (bclk_rise) begin
        prev_lrck_reg <= lrck_s;
      end

      // Completion flags are raised on the capturing bclk rise and acted on
      // one clock later, so outputs and strobes move one cycle after capture.
      // Successive bclk rises are at least four clocks apart, so shift_reg is
      // still stable when these flags are consumed.
      if (done_left_reg) begin
        left_hold_reg <= align(shift_reg);
        left_ok_reg   <= 1'b1;
      end
      if (done_right_reg && left_ok_reg) begin
        audio_l_reg     <= left_hold_reg;
        audio_r_reg     <= align(shift_reg);
        audio_valid_reg <= 1'b1;
        left_ok_reg     <= 1'b0;
      end
      if (short_reg) begin
        sample_error_reg <= 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          // Only a right-to-left word-select change starts capture, so any
          // partial frame seen after reset is dropped.
          if (bclk_rise && prev_lrck_reg && !lrck_s) begin
            state_reg <= S_DELAY;
          end
        end
        S_DELAY: begin
          // The boundary rise that brought us here is the one-bit I2S delay;
          // the MSB is carried by the next rise, which SHIFT will take.
          bit_cnt_reg <= '0;
          channel_reg <= lrck_s;
          state_reg   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (bclk_rise) begin
            shift_reg <= {shift_reg[SAMPLE_WIDTH-2:0], adcdat_s};
            if (bit_cnt_reg == 6'(SAMPLE_WIDTH - 1)) begin
              // Final bit wins over a coincident boundary; that boundary
              // rise is then also the delay bit of the next slot.
              done_left_reg  <= ~channel_reg;
              done_right_reg <= channel_reg;
              state_reg      <= boundary ? S_DELAY : S_WAIT;
            end else if (boundary) begin
              short_reg   <= 1'b1;
              left_ok_reg <= 1'b0;
              state_reg   <= S_DELAY;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 6'd1;
            end
          end
        end
        S_WAIT: begin
          if (bclk_rise && boundary) begin
            state_reg <= S_DELAY;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.audio_out_L  = audio_l_reg;
  assign bus.audio_out_R  = audio_r_reg;
  assign bus.audio_valid  = audio_valid_reg;
  assign bus.sample_error = sample_error_reg;

endmodule

// File: tb/tb_i2s_audio_rx.sv
// tb_i2s_audio_rx
//   Directed bench for i2s_audio_rx (SAMPLE_WIDTH = 24). Serial data is
//   driven with lrck/adcdat changing on bclk falling edges; a negedge monitor
//   records strobes, their cycle stamps and the sample values.
module tb_i2s_audio_rx;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  i2s_audio_rx_if bus ();

  i2s_audio_rx #(.SAMPLE_WIDTH(24)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  int valid_cnt = 0;
  int err_cnt   = 0;
  int valid_cyc = -1;
  int err_cyc   = -1;
  logic [31:0] got_l[$];
  logic [31:0] got_r[$];

  int first_cyc = 0;
  int lsb_cyc   = 0;

  always @(negedge clock) begin
    if (bus.audio_valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
      got_l.push_back(bus.audio_out_L);
      got_r.push_back(bus.audio_out_R);
    end
    if (bus.sample_error === 1'b1) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] check %s observed %h expected %h", tag, obs, exp);
  endtask

  // One bclk period: falling edge (with new lrck/data), then rising edge.
  task automatic send_bit(input logic lr, input logic d, input int half, output int rise);
    bus.bclk   = 1'b0;
    bus.lrck   = lr;
    bus.adcdat = d;
    repeat (half) @(posedge clock);
    #1;
    bus.bclk = 1'b1;
    rise     = cyc;
    repeat (half) @(posedge clock);
    #1;
  endtask

  // Rise 1 carries first_bit (delay bit), rises 2..25 carry w MSB first.
  task automatic send_slot(input logic lr, input logic [23:0] w, input int n,
                           input int half, input logic first_bit);
    int   r;
    logic d;
    for (int k = 1; k <= n; k++) begin
      if (k == 1)       d = first_bit;
      else if (k <= 25) d = w[25-k];
      else              d = 1'b0;
      send_bit(lr, d, half, r);
      if (k == 1)  first_cyc = r;
      if (k == 25) lsb_cyc   = r;
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                            input int n, input int half);
    send_slot(1'b0, l, n, half, 1'b0);
    send_slot(1'b1, r, n, half, 1'b0);
  endtask

  task automatic idle_rises(input int n, input int half);
    int r;
    for (int k = 0; k < n; k++) send_bit(1'b1, 1'b0, half, r);
  endtask

  logic [23:0] el [100];
  logic [23:0] er [100];
  int v0, e0, q0;

  initial begin
    bus.bclk   = 1'b0;
    bus.lrck   = 1'b1;
    bus.adcdat = 1'b0;
    reset_n    = 1'b0;
    @(posedge clock);
    #1;

    // Reset held with bclk running and a full frame on the wire
    send_frame(24'hFFFFFF, 24'hFFFFFF, 32, 2);
    chk("rst_out_L", bus.audio_out_L, 32'h0);
    chk("rst_out_R", bus.audio_out_R, 32'h0);
    chk("rst_valid", 32'(bus.audio_valid), 32'h0);
    chk("rst_error", 32'(bus.sample_error), 32'h0);
    chk("rst_no_strobe", valid_cnt, 0);

    // Release with lrck constant: nothing happens
    reset_n = 1'b1;
    idle_rises(40, 8);
    chk("rel_no_valid", valid_cnt, 0);
    chk("rel_no_error", err_cnt, 0);

    // Nominal frames, 64 bclk per frame
    send_frame(24'h800001, 24'h7FFFFF, 32, 8);
    chk("nom1_count", valid_cnt, 1);
    chk("nom1_L", bus.audio_out_L, 32'h80000100);
    chk("nom1_R", bus.audio_out_R, 32'h7FFFFF00);
    chk("nom1_latency", valid_cyc, lsb_cyc + 4);
    send_frame(24'h000001, 24'hC00000, 32, 8);
    chk("nom2_count", valid_cnt, 2);
    chk("nom2_L", bus.audio_out_L, 32'h00000100);
    chk("nom2_R", bus.audio_out_R, 32'hC0000000);
    chk("nom2_latency", valid_cyc, lsb_cyc + 4);
    idle_rises(10, 8);
    chk("hold_L", bus.audio_out_L, 32'h00000100);
    chk("hold_R", bus.audio_out_R, 32'hC0000000);
    chk("nom_no_error", err_cnt, 0);

    // Mid-frame start: reset released during a right slot
    reset_n = 1'b0;
    #1;
    chk("mid_rst_L", bus.audio_out_L, 32'h0);
    chk("mid_rst_R", bus.audio_out_R, 32'h0);
    v0 = valid_cnt;
    begin
      int r;
      for (int k = 0; k < 6; k++) send_bit(1'b1, 1'b1, 8, r);
    end
    reset_n = 1'b1;
    send_slot(1'b1, 24'hABCDEF, 32, 8, 1'b0);
    chk("mid_no_valid", valid_cnt - v0, 0);
    send_frame(24'hA5A5A5, 24'h5A5A5A, 32, 8);
    chk("mid_count", valid_cnt - v0, 1);
    chk("mid_L", bus.audio_out_L, 32'hA5A5A500);
    chk("mid_R", bus.audio_out_R, 32'h5A5A5A00);

    // Short left slot: 10 bits, then lrck toggles
    v0 = valid_cnt;
    e0 = err_cnt;
    send_slot(1'b0, 24'h3C3C3C, 11, 8, 1'b0);
    send_slot(1'b1, 24'h0F0F0F, 32, 8, 1'b0);
    chk("short_error", err_cnt - e0, 1);
    chk("short_no_valid", valid_cnt - v0, 0);
    chk("short_err_latency", err_cyc, first_cyc + 4);
    send_frame(24'h123456, 24'hFEDCBA, 32, 8);
    chk("after_short_count", valid_cnt - v0, 1);
    chk("after_short_L", bus.audio_out_L, 32'h12345600);
    chk("after_short_R", bus.audio_out_R, 32'hFEDCBA00);
    chk("after_short_err", err_cnt - e0, 1);

    // Boundary coinciding with the final left bit is not an error
    e0 = err_cnt;
    send_slot(1'b0, 24'h0F1E2D, 24, 8, 1'b0);
    send_slot(1'b1, 24'h3C4B5A, 32, 8, 1'b1);
    chk("coinc_no_error", err_cnt - e0, 0);
    send_frame(24'h13579B, 24'h2468AC, 32, 8);
    chk("coinc_next_L", bus.audio_out_L, 32'h13579B00);
    chk("coinc_next_R", bus.audio_out_R, 32'h2468AC00);

    // Minimum-length slots at maximum bclk rate, random data
    v0 = valid_cnt;
    e0 = err_cnt;
    q0 = got_l.size();
    for (int i = 0; i < 100; i++) begin
      el[i] = 24'($urandom);
      er[i] = 24'($urandom);
      send_frame(el[i], er[i], 25, 2);
    end
    repeat (10) @(posedge clock);
    #1;
    chk("max_count", valid_cnt - v0, 100);
    chk("max_no_error", err_cnt - e0, 0);
    if (got_l.size() >= q0 + 100) begin
      for (int i = 0; i < 100; i++) begin
        chk($sformatf("max_L_%0d", i), got_l[q0+i], {el[i], 8'h00});
        chk($sformatf("max_R_%0d", i), got_r[q0+i], {er[i], 8'h00});
      end
    end

    // Reset pulse partway through a left slot
    send_frame(24'h445566, 24'h778899, 32, 8);
    chk("pre_rst_L", bus.audio_out_L, 32'h44556600);
    v0 = valid_cnt;
    send_slot(1'b0, 24'hDEADBE, 9, 8, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("pulse_L", bus.audio_out_L, 32'h0);
    chk("pulse_R", bus.audio_out_R, 32'h0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    send_slot(1'b0, 24'hDEADBE, 23, 8, 1'b0);
    send_slot(1'b1, 24'h999999, 32, 8, 1'b0);
    chk("pulse_no_valid", valid_cnt - v0, 0);
    chk("pulse_hold_L", bus.audio_out_L, 32'h0);
    send_frame(24'hCAFE12, 24'h00BEEF, 32, 8);
    chk("pulse_count", valid_cnt - v0, 1);
    chk("pulse_L_after", bus.audio_out_L, 32'hCAFE1200);
    chk("pulse_R_after", bus.audio_out_R, 32'h00BEEF00);
    chk("pulse_latency", valid_cyc, lsb_cyc + 4);

    repeat (5) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
